// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave datapath and spi_ram_burst.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              rd_overrun;
  logic [ADDR_W-1:0] w_addr_o;

  modport master (output din, rx_valid, tx_ready,
                  input  dout, tx_valid, rd_overrun, w_addr_o);
  modport slave  (input  din, rx_valid, tx_ready,
                  output dout, tx_valid, rd_overrun, w_addr_o);
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind the SPI slave: 2-bit command decode, burst addressing,
// tx_ready back-pressure and read-overrun pulse. Define RAM_AUTO_INC_EN for bursts.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input logic            clk,
  input logic            rst_n,
  spi_ram_burst_if.slave bus
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [DATA_W-1:0] dout;
  logic              tx_valid, rd_overrun;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              w_in, r_in, wr_en, rd_cmd, rd_acc, rd_drop;
  logic [DATA_W-1:0] rdata;

  assign cmd     = bus.din[DATA_W+1:DATA_W];
  assign payload = bus.din[DATA_W-1:0];
  assign w_in    = {1'b0, w_addr} < DEPTH_C;
  assign r_in    = {1'b0, r_addr} < DEPTH_C;
  assign wr_en   = bus.rx_valid && (cmd == 2'b01) && w_in;
  assign rd_cmd  = bus.rx_valid && (cmd == 2'b11);
  // A read may replace pending data only if that data is consumed this cycle.
  assign rd_acc  = rd_cmd && (!tx_valid || bus.tx_ready);
  assign rd_drop = rd_cmd && tx_valid && !bus.tx_ready;
  assign rdata   = r_in ? mem[r_addr[IDX_W-1:0]] : '0;

`ifdef RAM_AUTO_INC_EN
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(MEM_DEPTH - 1);
  // Out-of-range pointers wrap to 0 as well as the last valid word.
  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= LAST_C) ? '0 : a + 1'b1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr[IDX_W-1:0]] <= payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_addr     <= '0;
      r_addr     <= '0;
      dout       <= '0;
      tx_valid   <= 1'b0;
      rd_overrun <= 1'b0;
    end else begin
      rd_overrun <= rd_drop;
      if (bus.rx_valid) begin
        case (cmd)
          2'b00: w_addr <= payload[ADDR_W-1:0];
`ifdef RAM_AUTO_INC_EN
          2'b01: w_addr <= adv(w_addr);
`endif
          2'b10: r_addr <= payload[ADDR_W-1:0];
`ifdef RAM_AUTO_INC_EN
          2'b11: if (rd_acc) r_addr <= adv(r_addr);
`endif
          default: ;
        endcase
      end
      if (rd_acc) begin
        dout     <= rdata;
        tx_valid <= 1'b1;
      end else if (tx_valid && bus.tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout;
  assign bus.tx_valid   = tx_valid;
  assign bus.rd_overrun = rd_overrun;
  assign bus.w_addr_o   = w_addr;
endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised single-port RAM that sits behind the SPI slave. It decodes 2-bit command words from the SPI receive path: set write address, write data, set read address, read data. Over the previous-generation RAM it adds independent data and address widths, non-power-of-2 depth, address auto-increment for burst transfers, a tx_ready back-pressure handshake toward the SPI transmit path, and read-overrun reporting.

Parameters:
DATA_W, 8, width of a memory word and of dout
ADDR_W, 8, width of the write and read address registers; must satisfy ADDR_W <= DATA_W
MEM_DEPTH, 256, number of words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_W

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  reset, synchronous, active-low
din  input  DATA_W+2  command word: din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload
rx_valid  input  1  din valid this cycle; one command consumed per cycle
dout  output  DATA_W  read data toward the SPI transmit path
tx_valid  output  1  dout holds unconsumed read data
tx_ready  input  1  transmit path accepts dout when tx_valid && tx_ready
rd_overrun  output  1  one-cycle pulse: a read command was dropped
w_addr_o  output  ADDR_W  current write pointer (debug/status)

Behaviour:
- Reset (rst_n=0 at a clk edge): dout=0, tx_valid=0, rd_overrun=0, w_addr=0, r_addr=0. Memory contents are not reset. Reset wins over every other event, including mid-burst and with tx_valid pending.
- Commands act only when rx_valid=1. With rx_valid=0, state is held except for the handshake clear below.
- cmd 00 (set write address): w_addr <= payload[ADDR_W-1:0].
- cmd 01 (write data): if w_addr < MEM_DEPTH, mem[w_addr] <= payload; otherwise the write is dropped. w_addr then advances.
- cmd 10 (set read address): r_addr <= payload[ADDR_W-1:0].
- cmd 11 (read data) is accepted when tx_valid=0, or when tx_valid && tx_ready in the same cycle. On accept:
  - dout <= mem[r_addr] if r_addr < MEM_DEPTH, else 0
  - tx_valid <= 1
  - r_addr advances
- If cmd 11 arrives while tx_valid=1 and tx_ready=0: the command is dropped; dout, tx_valid and r_addr are unchanged; rd_overrun=1 for the next cycle only.
- Handshake: tx_valid && tx_ready with no accepted read in that cycle gives tx_valid <= 0; dout keeps its last value. While tx_valid=1 and tx_ready=0, dout is held stable.
- Latency: a read command accepted at edge N gives valid dout/tx_valid after edge N. A write at cycle N followed by a read of the same address at N+1 returns the new data (read-after-write).
- Address advance rule (w_addr and r_addr independently): next = 0 if addr >= MEM_DEPTH-1, else addr+1. An out-of-range address therefore wraps to 0.
- Commands 00/01/10 never change tx_valid or dout; a pending read survives address updates.
- Memory inferred as a synchronous single-port array: one write or one read per cycle, never both.

Optional Feature:
- Macro: RAM_AUTO_INC_EN.
- Defined: addresses advance as described above, so consecutive cmd 01 or cmd 11 words form a burst.
- Undefined: w_addr and r_addr change only on cmd 00 and cmd 10 respectively, matching the previous-generation RAM. Repeated reads return the same word; repeated writes overwrite the same location. All other behaviour is identical.

Test Plan:
1. Reset, then set w_addr=0x10 and write 0xA5; set r_addr=0x10 and read with tx_ready=1 -> dout=0xA5, tx_valid=1 one cycle after the read, then 0 after the handshake.
2. (AUTO_INC) Set w_addr=0xFE, write 0x11, 0x22, 0x33; set r_addr=0xFE, read x3 -> dout sequence 0x11, 0x22, 0x33, locations 0xFE/0xFF/0x00 wrap correctly, w_addr_o=0x01.
3. Read with tx_ready=0 held, then issue a second read -> dout unchanged, rd_overrun pulses exactly 1 cycle, r_addr not advanced; raise tx_ready -> tx_valid drops.
4. tx_valid=1, tx_ready=1 and a read in the same cycle -> tx_valid stays 1, dout updates to the next word, no overrun.
5. MEM_DEPTH=200: set w_addr=0xC8, write 0x5A; set r_addr=0xC8 and read -> dout=0x00, w_addr_o=0x00 after the write, no memory location corrupted.
6. Assert rst_n=0 mid-burst with tx_valid=1 -> next cycle tx_valid=0, dout=0, w_addr_o=0, rd_overrun=0; previously written data is still readable.
